// File: rtl/cdp_dp_lut_ctrl_v2_pkg.sv
// Shared types, widths and index helpers for the CDP LUT index controller.
package cdp_dp_lut_ctrl_v2_pkg;

   localparam int unsigned ENTRY_W = 10;
   localparam int unsigned FRAC_W  = 16;
   localparam int unsigned INFO_W  = 18;
   localparam int unsigned START_W = 38;
   localparam int unsigned X_W     = 39;
   localparam int unsigned LE_MAX  = 64;
   localparam int unsigned LO_MAX  = 256;

   typedef struct packed {
      logic              uflow;
      logic              oflow;
      logic [FRAC_W-1:0] frac;
   } lut_info_t;

   typedef struct packed {
      logic [ENTRY_W-1:0] entry;
      lut_info_t          info;
   } lut_res_t;

   typedef enum logic {LeExp = 1'b0, LeLin = 1'b1} le_mode_e;

   // Linear index: bits above the shift point form the index, the 16 below it the fraction.
   function automatic lut_res_t lin_map(input logic [X_W-1:0]     x,
                                        input logic [7:0]         sel,
                                        input logic [ENTRY_W-1:0] max_idx);
      logic [X_W+FRAC_W-1:0] wide;
      lut_res_t              r;
      wide = {x, {FRAC_W{1'b0}}} >> sel;
      r    = '0;
      if (wide[X_W+FRAC_W-1:FRAC_W] > X_W'(max_idx)) begin
         r.entry      = max_idx;
         r.info.oflow = 1'b1;
      end else begin
         r.entry     = wide[FRAC_W +: ENTRY_W];
         r.info.frac = wide[FRAC_W-1:0];
      end
      return r;
   endfunction

   function automatic logic [5:0] lead_one(input logic [X_W-1:0] x);
      logic [5:0] p;
      p = '0;
      for (int i = 0; i < int'(X_W); i++) begin
         if (x[i]) p = 6'(i);
      end
      return p;
   endfunction

endpackage

// File: rtl/cdp_lut_idx_lane.sv
// One lane of LUT index math: S1 subtracts the table starts, S2 shifts and clamps.
module cdp_lut_idx_lane
   import cdp_dp_lut_ctrl_v2_pkg::*;
#(
   parameter int unsigned SQW = 21
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               s1_en_i,
   input  logic               s2_en_i,
   input  logic [SQW-1:0]     lane_i,
   input  logic               sqsum_bypass_i,
   input  logic [START_W-1:0] le_start_i,
   input  logic [START_W-1:0] lo_start_i,
   input  le_mode_e           le_mode_i,
   input  logic [7:0]         le_index_offset_i,
   input  logic [7:0]         le_index_select_i,
   input  logic [7:0]         lo_index_select_i,
   output logic [ENTRY_W-1:0] x_entry_o,
   output lut_info_t          x_info_o,
   output logic [ENTRY_W-1:0] y_entry_o,
   output lut_info_t          y_info_o
);

   localparam int unsigned DW = X_W + 1;

   logic [DW-1:0]      lane_ext, le_diff, lo_diff;
   logic [X_W-1:0]     le_x_q, le_x_d, lo_x_q, lo_x_d;
   logic               le_neg_q, le_neg_d, lo_neg_q, lo_neg_d;
   logic [ENTRY_W-1:0] x_entry_q, y_entry_q;
   lut_info_t          x_info_q, y_info_q;
   lut_res_t           le_res, lo_res, le_lin;
   logic [5:0]         lead_pos;
   logic signed [9:0]  exp_idx;
   logic [FRAC_W-1:0]  exp_frac;

   // Starts are treated as signed 38-bit values; one guard bit keeps the sign of the difference.
   always_comb begin
      lane_ext = sqsum_bypass_i ? {{(DW-SQW){lane_i[SQW-1]}}, lane_i}
                                : {{(DW-SQW){1'b0}}, lane_i};
      le_diff  = lane_ext - {{(DW-START_W){le_start_i[START_W-1]}}, le_start_i};
      lo_diff  = lane_ext - {{(DW-START_W){lo_start_i[START_W-1]}}, lo_start_i};
      le_x_d   = le_diff[X_W-1:0];
      le_neg_d = le_diff[DW-1];
      lo_x_d   = lo_diff[X_W-1:0];
      lo_neg_d = lo_diff[DW-1];
   end

   // Exponential offset is signed so that the upper clamp is reachable.
   always_comb begin
      lead_pos = lead_one(le_x_q);
      exp_idx  = $signed({4'b0000, lead_pos}) - $signed({{2{le_index_offset_i[7]}},
                                                         le_index_offset_i});
      exp_frac = FRAC_W'({le_x_q, {FRAC_W{1'b0}}} >> lead_pos);
      le_lin   = lin_map(le_x_q, le_index_select_i, ENTRY_W'(LE_MAX));
      le_res   = '0;
      if (le_neg_q) begin
         le_res.info.uflow = 1'b1;
      end else if (le_mode_i == LeLin) begin
         le_res = le_lin;
      end else if ((le_x_q == '0) || exp_idx[9]) begin
         le_res.info.uflow = 1'b1;
      end else if ($unsigned(exp_idx) > ENTRY_W'(LE_MAX)) begin
         le_res.entry      = ENTRY_W'(LE_MAX);
         le_res.info.oflow = 1'b1;
      end else begin
         le_res.entry     = $unsigned(exp_idx);
         le_res.info.frac = exp_frac;
      end

      lo_res = '0;
      if (lo_neg_q) begin
         lo_res.info.uflow = 1'b1;
      end else begin
         lo_res = lin_map(lo_x_q, lo_index_select_i, ENTRY_W'(LO_MAX));
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         le_x_q    <= '0;
         le_neg_q  <= 1'b0;
         lo_x_q    <= '0;
         lo_neg_q  <= 1'b0;
         x_entry_q <= '0;
         x_info_q  <= '0;
         y_entry_q <= '0;
         y_info_q  <= '0;
      end else begin
         if (s1_en_i) begin
            le_x_q   <= le_x_d;
            le_neg_q <= le_neg_d;
            lo_x_q   <= lo_x_d;
            lo_neg_q <= lo_neg_d;
         end
         if (s2_en_i) begin
            x_entry_q <= le_res.entry;
            x_info_q  <= le_res.info;
            y_entry_q <= lo_res.entry;
            y_info_q  <= lo_res.info;
         end
      end
   end

   assign x_entry_o = x_entry_q;
   assign x_info_o  = x_info_q;
   assign y_entry_o = y_entry_q;
   assign y_info_o  = y_info_q;

endmodule

// File: rtl/cdp_dp_lut_ctrl_v2.sv
// CDP LUT index controller: input/sync fork, two-stage lane pipeline, LE flag counters.
module cdp_dp_lut_ctrl_v2
   import cdp_dp_lut_ctrl_v2_pkg::*;
#(
   parameter int unsigned TP  = 1,
   parameter int unsigned SQW = 21
) (
   input  logic                  nvdla_core_clk,
   input  logic                  nvdla_core_rst,
   input  logic                  sum2itp_pvld,
   output logic                  sum2itp_prdy,
   input  logic [TP*SQW-1:0]     sum2itp_pd,
   output logic                  sum2sync_pvld,
   input  logic                  sum2sync_prdy,
   output logic [TP*SQW-1:0]     sum2sync_pd,
   input  logic                  reg2dp_lut_le_function,
   input  logic [7:0]            reg2dp_lut_le_index_offset,
   input  logic [7:0]            reg2dp_lut_le_index_select,
   input  logic [7:0]            reg2dp_lut_lo_index_select,
   input  logic [START_W-1:0]    reg2dp_lut_le_start,
   input  logic [START_W-1:0]    reg2dp_lut_lo_start,
   input  logic                  reg2dp_sqsum_bypass,
   input  logic                  reg2dp_perf_clr,
   output logic                  dp2lut_pvld,
   input  logic                  dp2lut_prdy,
   output logic [TP*ENTRY_W-1:0] dp2lut_X_entry,
   output logic [TP*ENTRY_W-1:0] dp2lut_Y_entry,
   output logic [TP*INFO_W-1:0]  dp2lut_Xinfo,
   output logic [TP*INFO_W-1:0]  dp2lut_Yinfo,
   output logic [31:0]           dp2reg_lut_uflow_cnt,
   output logic [31:0]           dp2reg_lut_oflow_cnt
);

   logic        s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
   logic        pipe_in_rdy, s2_rdy, in_fire, s2_load, out_fire;
   le_mode_e    le_mode_q, le_mode_d;
   logic [7:0]  le_off_q, le_off_d, le_sel_q, le_sel_d, lo_sel_q, lo_sel_d;
   logic [31:0] uf_cnt_q, uf_cnt_d, of_cnt_q, of_cnt_d;
   logic [3:0]  uf_inc, of_inc;

   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [3:0] b);
      logic [32:0] s;
      s = {1'b0, a} + 33'(b);
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction

   // The sync FIFO and the pipeline advance together or not at all.
   always_comb begin
      s2_rdy        = !s2_vld_q || dp2lut_prdy;
      pipe_in_rdy   = !s1_vld_q || s2_rdy;
      in_fire       = sum2itp_pvld && pipe_in_rdy && sum2sync_prdy;
      s2_load       = s2_rdy && s1_vld_q;
      out_fire      = s2_vld_q && dp2lut_prdy;
      sum2itp_prdy  = pipe_in_rdy && sum2sync_prdy;
      sum2sync_pvld = sum2itp_pvld && pipe_in_rdy;
      sum2sync_pd   = sum2itp_pd;

      s1_vld_d = pipe_in_rdy ? in_fire : s1_vld_q;
      s2_vld_d = s2_rdy ? s1_vld_q : s2_vld_q;

      le_mode_d = in_fire ? le_mode_e'(reg2dp_lut_le_function) : le_mode_q;
      le_off_d  = in_fire ? reg2dp_lut_le_index_offset : le_off_q;
      le_sel_d  = in_fire ? reg2dp_lut_le_index_select : le_sel_q;
      lo_sel_d  = in_fire ? reg2dp_lut_lo_index_select : lo_sel_q;
   end

   always_comb begin
      uf_inc = '0;
      of_inc = '0;
      for (int m = 0; m < int'(TP); m++) begin
         uf_inc = uf_inc + 4'(dp2lut_Xinfo[m*INFO_W + INFO_W - 1]);
         of_inc = of_inc + 4'(dp2lut_Xinfo[m*INFO_W + INFO_W - 2]);
      end
      uf_cnt_d = uf_cnt_q;
      of_cnt_d = of_cnt_q;
      if (reg2dp_perf_clr) begin
         uf_cnt_d = '0;
         of_cnt_d = '0;
      end else if (out_fire) begin
         uf_cnt_d = sat_add(uf_cnt_q, uf_inc);
         of_cnt_d = sat_add(of_cnt_q, of_inc);
      end
   end

   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         s1_vld_q  <= 1'b0;
         s2_vld_q  <= 1'b0;
         le_mode_q <= LeExp;
         le_off_q  <= '0;
         le_sel_q  <= '0;
         lo_sel_q  <= '0;
         uf_cnt_q  <= '0;
         of_cnt_q  <= '0;
      end else begin
         s1_vld_q  <= s1_vld_d;
         s2_vld_q  <= s2_vld_d;
         le_mode_q <= le_mode_d;
         le_off_q  <= le_off_d;
         le_sel_q  <= le_sel_d;
         lo_sel_q  <= lo_sel_d;
         uf_cnt_q  <= uf_cnt_d;
         of_cnt_q  <= of_cnt_d;
      end
   end

   for (genvar m = 0; m < int'(TP); m++) begin : g_lane
      cdp_lut_idx_lane #(
         .SQW (SQW)
      ) u_lane (
         .clk_i             (nvdla_core_clk),
         .rst_i             (nvdla_core_rst),
         .s1_en_i           (in_fire),
         .s2_en_i           (s2_load),
         .lane_i            (sum2itp_pd[m*SQW +: SQW]),
         .sqsum_bypass_i    (reg2dp_sqsum_bypass),
         .le_start_i        (reg2dp_lut_le_start),
         .lo_start_i        (reg2dp_lut_lo_start),
         .le_mode_i         (le_mode_q),
         .le_index_offset_i (le_off_q),
         .le_index_select_i (le_sel_q),
         .lo_index_select_i (lo_sel_q),
         .x_entry_o         (dp2lut_X_entry[m*ENTRY_W +: ENTRY_W]),
         .x_info_o          (dp2lut_Xinfo[m*INFO_W +: INFO_W]),
         .y_entry_o         (dp2lut_Y_entry[m*ENTRY_W +: ENTRY_W]),
         .y_info_o          (dp2lut_Yinfo[m*INFO_W +: INFO_W])
      );
   end

   assign dp2lut_pvld          = s2_vld_q;
   assign dp2reg_lut_uflow_cnt = uf_cnt_q;
   assign dp2reg_lut_oflow_cnt = of_cnt_q;

endmodule

// File: tb/tb_cdp_dp_lut_ctrl_v2.sv
// Directed bench for cdp_dp_lut_ctrl_v2 with four lanes: vector table plus handshake sequences.
module tb_cdp_dp_lut_ctrl_v2;

   localparam int TP  = 4;
   localparam int SQW = 21;

   logic              clk = 1'b0;
   logic              rst;
   logic              sum2itp_pvld, sum2itp_prdy;
   logic [TP*SQW-1:0] sum2itp_pd;
   logic              sum2sync_pvld, sum2sync_prdy;
   logic [TP*SQW-1:0] sum2sync_pd;
   logic              le_fn, byp, perf_clr;
   logic [7:0]        le_off, le_sel, lo_sel;
   logic [37:0]       le_start, lo_start;
   logic              dp2lut_pvld, dp2lut_prdy;
   logic [TP*10-1:0]  x_entry, y_entry;
   logic [TP*18-1:0]  x_info, y_info;
   logic [31:0]       uf_cnt, of_cnt;

   cdp_dp_lut_ctrl_v2 #(
      .TP  (TP),
      .SQW (SQW)
   ) dut (
      .nvdla_core_clk             (clk),
      .nvdla_core_rst             (rst),
      .sum2itp_pvld               (sum2itp_pvld),
      .sum2itp_prdy               (sum2itp_prdy),
      .sum2itp_pd                 (sum2itp_pd),
      .sum2sync_pvld              (sum2sync_pvld),
      .sum2sync_prdy              (sum2sync_prdy),
      .sum2sync_pd                (sum2sync_pd),
      .reg2dp_lut_le_function     (le_fn),
      .reg2dp_lut_le_index_offset (le_off),
      .reg2dp_lut_le_index_select (le_sel),
      .reg2dp_lut_lo_index_select (lo_sel),
      .reg2dp_lut_le_start        (le_start),
      .reg2dp_lut_lo_start        (lo_start),
      .reg2dp_sqsum_bypass        (byp),
      .reg2dp_perf_clr            (perf_clr),
      .dp2lut_pvld                (dp2lut_pvld),
      .dp2lut_prdy                (dp2lut_prdy),
      .dp2lut_X_entry             (x_entry),
      .dp2lut_Y_entry             (y_entry),
      .dp2lut_Xinfo               (x_info),
      .dp2lut_Yinfo               (y_info),
      .dp2reg_lut_uflow_cnt       (uf_cnt),
      .dp2reg_lut_oflow_cnt       (of_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        lin;
      logic [7:0]  off, lsel, osel;
      logic [37:0] les, los;
      logic        byp;
      logic [20:0] d0, dn;
      logic [9:0]  xe, ye;
      logic [17:0] xi, yi;
      int          duf, dof;
   } vec_t;

   vec_t       vecs[13];
   int         n_total = 0;
   int         n_pass  = 0;
   logic [31:0] want_uf = 0;
   logic [31:0] want_of = 0;
   logic [39:0] got_q[$];
   bit         mon_en = 0;
   logic [39:0] want40;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      n_total++;
      if (act === want) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, want);
   endtask

   task automatic set_cfg(input logic lin, input logic [7:0] off, input logic [7:0] lsel,
                          input logic [7:0] osel, input logic [37:0] les,
                          input logic [37:0] los, input logic b);
      le_fn = lin; le_off = off; le_sel = lsel; lo_sel = osel;
      le_start = les; lo_start = los; byp = b;
   endtask

   task automatic drive_lanes(input logic [20:0] d0, input logic [20:0] dn);
      sum2itp_pd = {dn, dn, dn, d0};
   endtask

   always @(negedge clk) begin
      if (mon_en && dp2lut_pvld && dp2lut_prdy) got_q.push_back(x_entry);
   end

   initial begin
      int sent;
      int k;
      //                lin   off    lsel   osel   le_start lo_start byp d0         dn
      //                xe      ye       xi         yi        duf dof
      vecs[0]  = '{1'b1, 8'd0,  8'd4,  8'd4,  38'd0,   38'd0,  1'b0, 21'h35,    21'h35,
                   10'd3,  10'd3,   18'h05000, 18'h05000, 0, 0};
      vecs[1]  = '{1'b1, 8'd0,  8'd2,  8'd0,  38'd100, 38'd0,  1'b0, 21'd50,    21'd200,
                   10'd0,  10'd50,  18'h20000, 18'h00000, 1, 0};
      vecs[2]  = '{1'b0, 8'd2,  8'd0,  8'd4,  38'd0,   38'd0,  1'b0, 21'h400,   21'h400,
                   10'd8,  10'd64,  18'h00000, 18'h00000, 0, 0};
      vecs[3]  = '{1'b0, 8'd2,  8'd0,  8'd0,  38'd0,   38'd0,  1'b0, 21'h0,     21'h400,
                   10'd0,  10'd0,   18'h20000, 18'h00000, 1, 0};
      vecs[4]  = '{1'b1, 8'd0,  8'd0,  8'd0,  38'd0,   38'd0,  1'b0, 21'd100,   21'd100,
                   10'd64, 10'd100, 18'h10000, 18'h00000, 0, 4};
      vecs[5]  = '{1'b1, 8'd0,  8'd1,  8'd1,  38'd0,   38'd0,  1'b0, 21'd129,   21'd129,
                   10'd64, 10'd64,  18'h08000, 18'h08000, 0, 0};
      vecs[6]  = '{1'b1, 8'd0,  8'd8,  8'd0,  38'd0,   38'd0,  1'b0, 21'd300,   21'd300,
                   10'd1,  10'd256, 18'h02C00, 18'h10000, 0, 0};
      vecs[7]  = '{1'b1, 8'd0,  8'd0,  8'd0,  38'd0,   38'd0,  1'b1, 21'h1FFFFF, 21'd5,
                   10'd0,  10'd0,   18'h20000, 18'h20000, 1, 0};
      vecs[8]  = '{1'b1, 8'd0,  8'd40, 8'd39, 38'd0,   38'd0,  1'b0, 21'h1FFFFF, 21'h1FFFFF,
                   10'd0,  10'd0,   18'h00000, 18'h00000, 0, 0};
      vecs[9]  = '{1'b0, 8'hC0, 8'd0,  8'd0,  38'd0,   38'd0,  1'b0, 21'h400,   21'h400,
                   10'd64, 10'd256, 18'h10000, 18'h10000, 0, 4};
      vecs[10] = '{1'b0, 8'd0,  8'd0,  8'd0,  38'd0,   38'd0,  1'b0, 21'h35,    21'h35,
                   10'd5,  10'd53,  18'h0A800, 18'h00000, 0, 0};
      vecs[11] = '{1'b0, 8'd20, 8'd0,  8'd4,  38'd0,   38'd0,  1'b0, 21'h400,   21'h400,
                   10'd0,  10'd64,  18'h20000, 18'h00000, 4, 0};
      vecs[12] = '{1'b1, 8'd0,  8'd0,  8'd0,  38'd0,   38'd10, 1'b0, 21'd5,     21'd5,
                   10'd5,  10'd0,   18'h00000, 18'h20000, 0, 0};

      rst = 1'b1; sum2itp_pvld = 0; sum2itp_pd = '0; sum2sync_prdy = 1; dp2lut_prdy = 1;
      perf_clr = 0;
      set_cfg(1'b0, 8'd0, 8'd0, 8'd0, 38'd0, 38'd0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_pvld", dp2lut_pvld, 0);
      check("rst_sync_pvld", sum2sync_pvld, 0);
      check("rst_x_entry", x_entry, 0);
      check("rst_x_info", x_info, 0);
      check("rst_y_entry", y_entry, 0);
      check("rst_uf_cnt", uf_cnt, 0);
      check("rst_of_cnt", of_cnt, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         set_cfg(vecs[i].lin, vecs[i].off, vecs[i].lsel, vecs[i].osel, vecs[i].les,
                 vecs[i].los, vecs[i].byp);
         drive_lanes(vecs[i].d0, vecs[i].dn);
         sum2itp_pvld = 1; dp2lut_prdy = 1;
         k = 0;
         @(negedge clk);
         while (!sum2itp_prdy && k < 10) begin @(negedge clk); k++; end
         check($sformatf("v%0d_in_prdy", i), sum2itp_prdy, 1);
         @(posedge clk); #1;
         sum2itp_pvld = 0;
         check($sformatf("v%0d_lat1", i), dp2lut_pvld, 0);
         @(posedge clk); #1;
         check($sformatf("v%0d_pvld", i), dp2lut_pvld, 1);
         check($sformatf("v%0d_xe", i), x_entry[9:0], vecs[i].xe);
         check($sformatf("v%0d_xi", i), x_info[17:0], vecs[i].xi);
         check($sformatf("v%0d_ye", i), y_entry[9:0], vecs[i].ye);
         check($sformatf("v%0d_yi", i), y_info[17:0], vecs[i].yi);
         want_uf = want_uf + 32'(vecs[i].duf);
         want_of = want_of + 32'(vecs[i].dof);
         @(posedge clk); #1;
         check($sformatf("v%0d_uf_cnt", i), uf_cnt, want_uf);
         check($sformatf("v%0d_of_cnt", i), of_cnt, want_of);
      end

      // Back-to-back stream: one group per cycle, two-cycle latency.
      set_cfg(1'b1, 8'd0, 8'd0, 8'd0, 38'd0, 38'd0, 1'b0);
      for (int c = 0; c < 6; c++) begin
         if (c >= 2) begin
            check($sformatf("tput%0d_pvld", c), dp2lut_pvld, 1);
            check($sformatf("tput%0d_xe", c), x_entry[9:0], 10'(c - 1));
         end
         sum2itp_pvld = (c < 4);
         drive_lanes(21'(c + 1), 21'(c + 1));
         @(posedge clk); #1;
      end
      sum2itp_pvld = 0;
      @(posedge clk); #1;
      check("tput_drain", dp2lut_pvld, 0);

      // Output stall with three groups offered.
      mon_en = 1; sent = 0; dp2lut_prdy = 0;
      for (int c = 0; c < 20; c++) begin
         if (c == 8) dp2lut_prdy = 1;
         sum2itp_pvld = (sent < 3);
         drive_lanes(21'(7 + sent), 21'(7 + sent));
         @(negedge clk);
         if (c == 6) begin
            want40 = {4{10'd7}};
            check("stall_in_prdy", sum2itp_prdy, 0);
            check("stall_out_pvld", dp2lut_pvld, 1);
            check("stall_hold", x_entry, want40);
         end
         if (sum2itp_pvld && sum2itp_prdy) sent++;
         @(posedge clk); #1;
      end
      sum2itp_pvld = 0; mon_en = 0;
      check("stall_count", got_q.size(), 3);
      for (int j = 0; j < 3; j++) begin
         want40 = {4{10'(7 + j)}};
         if (j < got_q.size()) check($sformatf("stall_order%0d", j), got_q[j], want40);
         else check($sformatf("stall_order%0d", j), 64'hDEAD, want40);
      end

      // Clear coincident with a handshake carrying four underflows.
      set_cfg(1'b0, 8'd2, 8'd0, 8'd0, 38'd0, 38'd0, 1'b0);
      drive_lanes(21'd0, 21'd0);
      dp2lut_prdy = 0; sum2itp_pvld = 1;
      @(posedge clk); #1;
      sum2itp_pvld = 0;
      @(posedge clk); #1;
      check("clr_parked", dp2lut_pvld, 1);
      perf_clr = 1; dp2lut_prdy = 1;
      @(posedge clk); #1;
      perf_clr = 0;
      check("clr_prio_uf", uf_cnt, 0);
      check("clr_prio_of", of_cnt, 0);
      sum2itp_pvld = 1;
      @(posedge clk); #1;
      sum2itp_pvld = 0;
      repeat (2) @(posedge clk);
      #1;
      check("clr_then_uf", uf_cnt, 4);

      // Sync FIFO back-pressure, then reset with S2 occupied.
      set_cfg(1'b1, 8'd0, 8'd0, 8'd0, 38'd100, 38'd0, 1'b0);
      drive_lanes(21'd11, 21'd11);
      sum2sync_prdy = 0; sum2itp_pvld = 1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check($sformatf("sync%0d_in_prdy", c), sum2itp_prdy, 0);
         check($sformatf("sync%0d_pvld", c), sum2sync_pvld, 1);
      end
      @(posedge clk); #1;
      check("sync_no_accept", dp2lut_pvld, 0);
      sum2sync_prdy = 1; dp2lut_prdy = 0;
      @(posedge clk); #1;
      sum2itp_pvld = 0;
      @(posedge clk); #1;
      check("rst2_full", dp2lut_pvld, 1);
      check("rst2_xi", x_info[17:0], 18'h20000);
      rst = 1;
      @(posedge clk); #1;
      check("rst2_pvld", dp2lut_pvld, 0);
      check("rst2_uf", uf_cnt, 0);
      check("rst2_of", of_cnt, 0);
      check("rst2_xe", x_entry, 0);
      rst = 0; dp2lut_prdy = 1;
      repeat (4) @(posedge clk);
      #1;
      check("rst2_stay_idle", dp2lut_pvld, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
